// File: rtl/arcino_pkg.sv
// Shared fetch-path types: fetch word width, buffered entry layout, RVC length decode.
// Pure declarations; no timing or flow control of its own.
package arcino_pkg;

    localparam int FETCH_W = 32;

    typedef struct packed {
        logic [FETCH_W-1:0] data;
        logic               err;
    } fetch_entry_t;

    function automatic logic is_compressed(input logic [1:0] lo_bits);
        return lo_bits != 2'b11;
    endfunction

endpackage

// File: rtl/arcino_fetch_aligner.sv
// Combinational 16/32-bit realigner over the two head words; zero latency.
// Never stalls: valid_o drops while the second half of a straddling instruction is absent.
module arcino_fetch_aligner
    import arcino_pkg::*;
(
    input  logic [FETCH_W-1:0] w0_i,
    input  logic [FETCH_W-1:0] w1_i,
    input  logic               w0_avail_i,
    input  logic               w1_avail_i,
    input  logic               w0_err_i,
    input  logic               w1_err_i,
    input  logic               pc1_i,
    output logic [FETCH_W-1:0] rdata_o,
    output logic               valid_o,
    output logic               err_o,
    output logic               pop_o,
    output logic [2:0]         pc_inc_o
);

    logic compressed;

    assign compressed = is_compressed(pc1_i ? w0_i[17:16] : w0_i[1:0]);
    assign rdata_o    = pc1_i ? {w1_i[15:0], w0_i[31:16]} : w0_i;
    assign valid_o    = w0_avail_i & (~pc1_i | compressed | w1_avail_i);
    assign err_o      = (w0_avail_i & w0_err_i)
                      | (pc1_i & ~compressed & w1_avail_i & w1_err_i);
    // Only an aligned compressed instruction leaves part of the head word unconsumed.
    assign pop_o      = pc1_i | ~compressed;
    assign pc_inc_o   = compressed ? 3'd2 : 3'd4;

endmodule

// File: rtl/arcino_fetch_fifo_cb.sv
// Circular-buffer fetch FIFO with instruction realignment; zero-latency bypass when empty.
// in_ready_o throttles requests by free-slot headroom; out side is valid/ready.
module arcino_fetch_fifo_cb
    import arcino_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 32,
    parameter int HEADROOM = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic [ADDR_W-1:0]          in_addr_i,
    input  logic [31:0]                in_rdata_i,
    input  logic                       in_err_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [31:0]                out_rdata_o,
    output logic [ADDR_W-1:0]          out_addr_o,
    output logic                       out_err_o,
    output logic                       out_valid_stored_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    fetch_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_nxt;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] pc_q, pc_d, head_pc;
    fetch_entry_t      e0, e1;
    logic              has1, has2, ovf, fire, push, pop_st, wr_en;
    logic              aln_pop;
    logic [2:0]        aln_pc_inc;

    assign rd_ptr_nxt = ptr_inc(rd_ptr_q);
    assign e0         = mem_q[rd_ptr_q];
    assign e1         = mem_q[rd_ptr_nxt];
    assign has1       = count_q != '0;
    assign has2       = count_q >= CNT_W'(2);
    assign head_pc    = has1 ? pc_q : in_addr_i;

    arcino_fetch_aligner u_aligner (
        .w0_i       (has1 ? e0.data : in_rdata_i),
        .w1_i       (has2 ? e1.data : in_rdata_i),
        .w0_avail_i (has1 | in_valid_i),
        .w1_avail_i (has2 | (has1 & in_valid_i)),
        .w0_err_i   (has1 ? e0.err : in_err_i),
        .w1_err_i   (has2 ? e1.err : in_err_i),
        .pc1_i      (head_pc[1]),
        .rdata_o    (out_rdata_o),
        .valid_o    (out_valid_o),
        .err_o      (out_err_o),
        .pop_o      (aln_pop),
        .pc_inc_o   (aln_pc_inc)
    );

    assign out_addr_o         = head_pc;
    assign out_valid_stored_o = has1 & (~pc_q[1] | is_compressed(e0.data[17:16]) | has2);
    assign count_o            = count_q;
    assign in_ready_o         = (DEPTH - int'(count_q)) >= HEADROOM;

    assign fire   = out_valid_o & out_ready_i;
    assign ovf    = in_valid_i & (count_q == CNT_W'(DEPTH));
    // A bypassed word that is fully consumed in its arrival cycle is never stored.
    assign push   = in_valid_i & ~(fire & aln_pop & ~has1);
    assign pop_st = fire & aln_pop & has1;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;
        wr_en    = 1'b0;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = {in_addr_i[ADDR_W-1:1], 1'b0};
        end else if (!ovf) begin
            wr_en    = push;
            wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            rd_ptr_d = pop_st ? rd_ptr_nxt : rd_ptr_q;
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop_st);
            if (fire) begin
                pc_d = head_pc + ADDR_W'(aln_pc_inc);
            end else if (!has1 && in_valid_i) begin
                pc_d = {in_addr_i[ADDR_W-1:1], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
        end
    end

    // Entries need no reset: count_q alone decides what is live.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= '{data: in_rdata_i, err: in_err_i};
        end
    end

    ovf_never: assert property (@(posedge clk_i) disable iff (rst_i)
        !(in_valid_i && count_q == CNT_W'(DEPTH) && !clear_i));

endmodule

// File: tb/tb_arcino_fetch_fifo_cb.sv
module tb_arcino_fetch_fifo_cb;

    localparam int DEPTH  = 5;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              clear_i = 1'b0;
    logic [ADDR_W-1:0] in_addr_i = 32'h88;
    logic [31:0]       in_rdata_i = 32'h1234_5678;
    logic              in_err_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [31:0]       out_rdata_o;
    logic [ADDR_W-1:0] out_addr_o;
    logic              out_err_o;
    logic              out_valid_stored_o;
    logic [CNT_W-1:0]  count_o;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] mask;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    arcino_fetch_fifo_cb #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HEADROOM(2)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .clear_i            (clear_i),
        .in_addr_i          (in_addr_i),
        .in_rdata_i         (in_rdata_i),
        .in_err_i           (in_err_i),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .out_valid_o        (out_valid_o),
        .out_ready_i        (out_ready_i),
        .out_rdata_o        (out_rdata_o),
        .out_addr_o         (out_addr_o),
        .out_err_o          (out_err_o),
        .out_valid_stored_o (out_valid_stored_o),
        .count_o            (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic expect_instr(input logic [31:0] addr, input logic [31:0] data,
                                input logic comp, input logic err);
        exp_t e;
        e.addr = addr;
        e.data = data;
        e.mask = comp ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic e, input logic rdy);
        in_valid_i  = v;
        in_addr_i   = a;
        in_rdata_i  = d;
        in_err_i    = e;
        out_ready_i = rdy;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard monitor: every accepted instruction is compared against the queue head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && !clear_i && out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_instr: got addr %h data %h want none", out_addr_o, out_rdata_o);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_addr", out_addr_o, e.addr);
                    check("instr_data", out_rdata_o & e.mask, e.data & e.mask);
                    check("instr_err", {31'b0, out_err_o}, {31'b0, e.err});
                end
            end
        end
    end

    initial begin
        // Reset state
        #2;
        check("rst_count", 32'(count_o), 0);
        check("rst_in_ready", 32'(in_ready_o), 1);
        check("rst_out_valid", 32'(out_valid_o), 0);
        check("rst_valid_stored", 32'(out_valid_stored_o), 0);
        check("rst_err", 32'(out_err_o), 0);
        check("rst_rdata_bypass", out_rdata_o, 32'h1234_5678);
        check("rst_addr_bypass", out_addr_o, 32'h88);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // 1. Aligned stream through the empty bypass
        expect_instr(32'h100, 32'h00B5_0513, 1'b0, 1'b0);
        expect_instr(32'h104, 32'h00C5_8593, 1'b0, 1'b0);
        drive(1, 32'h100, 32'h00B5_0513, 0, 1); tick();
        check("t1_count_after_first", 32'(count_o), 0);
        drive(1, 32'h104, 32'h00C5_8593, 0, 1); tick();
        check("t1_count_end", 32'(count_o), 0);

        // 2. Two compressed halves in one word: one pop total
        expect_instr(32'h200, 32'h0000_0505, 1'b1, 1'b0);
        expect_instr(32'h202, 32'h0000_4509, 1'b1, 1'b0);
        drive(1, 32'h200, 32'h4509_0505, 0, 1); tick();
        check("t2_count_mid", 32'(count_o), 1);
        drive(0, 32'h204, 32'h0, 0, 1); tick();
        check("t2_count_end", 32'(count_o), 0);

        // 3. Instruction straddling two words
        drive(1, 32'h302, 32'h0513_ABCD, 0, 1); tick();
        drive(0, 32'h306, 32'h0, 0, 1); #1;
        check("t3_wait_w1_valid", 32'(out_valid_o), 0);
        check("t3_wait_w1_stored", 32'(out_valid_stored_o), 0);
        check("t3_count_w0", 32'(count_o), 1);
        expect_instr(32'h302, 32'h00B5_0513, 1'b0, 1'b0);
        drive(1, 32'h306, 32'h0000_00B5, 0, 1); tick();
        drive(0, 32'h30A, 32'h0, 0, 0); #1;
        check("t3_pc_advanced", out_addr_o, 32'h306);
        check("t3_count_w1", 32'(count_o), 1);
        expect_instr(32'h306, 32'h0000_0000, 1'b1, 1'b0);
        drive(0, 32'h30A, 32'h0, 0, 1); tick();
        check("t3_count_end", 32'(count_o), 0);

        // 4. Error tagging on the second word of a straddling instruction
        drive(1, 32'h502, 32'h0513_ABCD, 0, 1); tick();
        expect_instr(32'h502, 32'h00B5_0513, 1'b0, 1'b1);
        drive(1, 32'h506, 32'h0000_00B5, 1, 1); tick();
        expect_instr(32'h506, 32'h0000_0000, 1'b1, 1'b1);
        drive(0, 32'h50A, 32'h0, 0, 1); tick();
        check("t4_count_drained", 32'(count_o), 0);
        drive(1, 32'h600, 32'h4509_0505, 0, 0); tick();
        drive(1, 32'h604, 32'hDEAD_BEEF, 1, 0); tick();
        drive(0, 32'h608, 32'h0, 0, 0); #1;
        check("t4_aligned_c_valid", 32'(out_valid_o), 1);
        check("t4_aligned_c_err", 32'(out_err_o), 0);
        expect_instr(32'h600, 32'h0000_0505, 1'b1, 1'b0);
        expect_instr(32'h602, 32'h0000_4509, 1'b1, 1'b0);
        expect_instr(32'h604, 32'hDEAD_BEEF, 1'b0, 1'b1);
        drive(0, 32'h608, 32'h0, 0, 1);
        for (int i = 0; i < 3; i++) tick();
        check("t4_count_end", 32'(count_o), 0);

        // 5. Fill to DEPTH, partial drain, refill across the wrap point
        for (int k = 0; k < 8; k++)
            expect_instr(32'h700 + 32'(4 * k), 32'hA500_0003 ^ (32'(k) << 12), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'h700 + 32'(4 * k), 32'hA500_0003 ^ (32'(k) << 12), 0, 0); tick();
            check("t5_fill_count", 32'(count_o), 32'(k + 1));
            check("t5_fill_in_ready", 32'(in_ready_o), (k + 1 <= 3) ? 32'd1 : 32'd0);
        end
        drive(0, 32'h714, 32'h0, 0, 0); #1;
        check("t5_full_stored_valid", 32'(out_valid_stored_o), 1);
        drive(0, 32'h714, 32'h0, 0, 1);
        for (int i = 0; i < 3; i++) tick();
        check("t5_drain3_count", 32'(count_o), 2);
        for (int k = 5; k < 8; k++) begin
            drive(1, 32'h700 + 32'(4 * k), 32'hA500_0003 ^ (32'(k) << 12), 0, 0); tick();
        end
        check("t5_refill_count", 32'(count_o), 5);
        check("t5_refill_in_ready", 32'(in_ready_o), 0);
        drive(0, 32'h720, 32'h0, 0, 1);
        for (int i = 0; i < 5; i++) tick();
        check("t5_count_end", 32'(count_o), 0);

        // 6. Flush during simultaneous push and pop
        drive(1, 32'h800, 32'h1111_0003, 0, 0); tick();
        drive(1, 32'h804, 32'h2222_0003, 0, 0); tick();
        drive(1, 32'h400, 32'h3333_0003, 0, 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        drive(0, 32'h400, 32'h0, 0, 0); #1;
        check("t6_clear_count", 32'(count_o), 0);
        check("t6_clear_addr", out_addr_o, 32'h400);
        check("t6_clear_stored", 32'(out_valid_stored_o), 0);
        check("t6_clear_valid", 32'(out_valid_o), 0);

        // Asynchronous reset in the middle of a stream
        drive(1, 32'h900, 32'h4444_0003, 0, 0); tick();
        drive(1, 32'h904, 32'h5555_0003, 0, 0); tick();
        check("t6_prerst_count", 32'(count_o), 2);
        drive(0, 32'h980, 32'hCAFE_F00D, 0, 0);
        #2;
        rst_i = 1'b1;
        #1;
        check("t6_arst_count", 32'(count_o), 0);
        check("t6_arst_stored", 32'(out_valid_stored_o), 0);
        check("t6_arst_valid", 32'(out_valid_o), 0);
        check("t6_arst_in_ready", 32'(in_ready_o), 1);
        check("t6_arst_rdata", out_rdata_o, 32'hCAFE_F00D);
        check("t6_arst_addr", out_addr_o, 32'h980);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Restart after reset
        expect_instr(32'hA00, 32'h00B5_0513, 1'b0, 1'b0);
        drive(1, 32'hA00, 32'h00B5_0513, 0, 1); tick();
        drive(0, 32'hA04, 32'h0, 0, 0); tick();
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
